// File: rtl/pipe_no_data_hazards_ex_pkg.sv
//==============================================================================
// Module : pipe_no_data_hazards_ex_pkg
// Brief  : Shared ALU opcodes, operand-select encodings and ID/EX record type.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package pipe_no_data_hazards_ex_pkg;

    // ALU operation codes; bit 3 only distinguishes sra from srl
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] SEL_QA  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [3:0]  aluc;
        logic [1:0]  sela;
        logic [1:0]  selb;
        logic [4:0]  wn;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm;
    } idex_t;

endpackage

`default_nettype wire

// File: rtl/pipe_no_data_hazards_ex_alu.sv
//==============================================================================
// Module : pipe_alu
// Brief  : 32-bit combinational ALU for the EX stage.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pipe_alu
    import pipe_no_data_hazards_ex_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  aluc_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = 32'h0;
        case (aluc_i[2:0])
            ALUC_ADD[2:0]: result_o = a_i + b_i;
            ALUC_SUB[2:0]: result_o = a_i - b_i;
            ALUC_AND[2:0]: result_o = a_i & b_i;
            ALUC_OR[2:0]:  result_o = a_i | b_i;
            ALUC_XOR[2:0]: result_o = a_i ^ b_i;
            ALUC_LUI[2:0]: result_o = {b_i[15:0], 16'h0000};
            ALUC_SLL[2:0]: result_o = b_i << a_i[4:0];
            ALUC_SRL[2:0]: begin
                // Shared low bits for srl/sra; bit 3 selects sign fill
                if (aluc_i[3])
                    result_o = 32'($signed(b_i) >>> a_i[4:0]);
                else
                    result_o = b_i >> a_i[4:0];
            end
            default:       result_o = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipe_no_data_hazards_ex.sv
//==============================================================================
// Module : pipe_no_data_hazards_ex
// Brief  : EX stage: ID/EX register, forwarding operand muxes and ALU.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pipe_no_data_hazards_ex
    import pipe_no_data_hazards_ex_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        IDwreg,
    input  logic        IDm2reg,
    input  logic        IDwmem,
    input  logic [3:0]  IDaluc,
    input  logic [1:0]  IDselectAlua,
    input  logic [1:0]  IDselectAlub,
    input  logic [4:0]  IDwn,
    input  logic [31:0] IDqa,
    input  logic [31:0] IDqb,
    input  logic [31:0] IDsaOrImme,
    input  logic [31:0] MEMaluResult,
    input  logic [31:0] WBdata,
    output logic        EXwreg,
    output logic        EXm2reg,
    output logic        EXwmem,
    output logic [4:0]  EXwn,
    output logic [31:0] EXaluResult,
    output logic [31:0] EXqb
);

    idex_t       idex_d;
    idex_t       idex_q;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    always_comb begin
        idex_d       = '0;
        idex_d.wreg  = IDwreg;
        idex_d.m2reg = IDm2reg;
        idex_d.wmem  = IDwmem;
        idex_d.aluc  = IDaluc;
        idex_d.sela  = IDselectAlua;
        idex_d.selb  = IDselectAlub;
        idex_d.wn    = IDwn;
        idex_d.qa    = IDqa;
        idex_d.qb    = IDqb;
        idex_d.imm   = IDsaOrImme;
    end

    // clrn is active-high despite its name
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    // Forwarded values come straight from later stages, not from the register
    always_comb begin
        alu_a = idex_q.qa;
        case (idex_q.sela)
            SEL_QA:  alu_a = idex_q.qa;
            SEL_MEM: alu_a = MEMaluResult;
            SEL_WB:  alu_a = WBdata;
            SEL_IMM: alu_a = idex_q.imm;
            default: alu_a = idex_q.qa;
        endcase
    end

    always_comb begin
        alu_b = idex_q.qb;
        case (idex_q.selb)
            SEL_QA:  alu_b = idex_q.qb;
            SEL_MEM: alu_b = MEMaluResult;
            SEL_WB:  alu_b = WBdata;
            SEL_IMM: alu_b = idex_q.imm;
            default: alu_b = idex_q.qb;
        endcase
    end

    pipe_alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .aluc_i   (idex_q.aluc),
        .result_o (EXaluResult)
    );

    assign EXwreg  = idex_q.wreg;
    assign EXm2reg = idex_q.m2reg;
    assign EXwmem  = idex_q.wmem;
    assign EXwn    = idex_q.wn;
    assign EXqb    = idex_q.qb;

endmodule

`default_nettype wire

// File: tb/tb_pipe_no_data_hazards_ex.sv
//==============================================================================
// Module : tb_pipe_no_data_hazards_ex
// Brief  : Scoreboard bench for the EX stage with directed vectors.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_pipe_no_data_hazards_ex;

    logic        clk;
    logic        clrn;
    logic        IDwreg, IDm2reg, IDwmem;
    logic [3:0]  IDaluc;
    logic [1:0]  IDselectAlua, IDselectAlub;
    logic [4:0]  IDwn;
    logic [31:0] IDqa, IDqb, IDsaOrImme;
    logic [31:0] MEMaluResult, WBdata;
    logic        EXwreg, EXm2reg, EXwmem;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult, EXqb;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] qb;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    pipe_no_data_hazards_ex dut (
        .clk          (clk),
        .clrn         (clrn),
        .IDwreg       (IDwreg),
        .IDm2reg      (IDm2reg),
        .IDwmem       (IDwmem),
        .IDaluc       (IDaluc),
        .IDselectAlua (IDselectAlua),
        .IDselectAlub (IDselectAlub),
        .IDwn         (IDwn),
        .IDqa         (IDqa),
        .IDqb         (IDqb),
        .IDsaOrImme   (IDsaOrImme),
        .MEMaluResult (MEMaluResult),
        .WBdata       (WBdata),
        .EXwreg       (EXwreg),
        .EXm2reg      (EXm2reg),
        .EXwmem       (EXwmem),
        .EXwn         (EXwn),
        .EXaluResult  (EXaluResult),
        .EXqb         (EXqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops each expectation and compares it against the live outputs
    initial begin
        forever begin
            wait (sb_q.size() != 0);
            #1;
            begin
                exp_t  e;
                exp_t  a;
                string n;
                e = sb_q.pop_front();
                n = name_q.pop_front();
                a = '{EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXqb};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got wreg=%0b m2reg=%0b wmem=%0b wn=%0d alu=%h qb=%h, want wreg=%0b m2reg=%0b wmem=%0b wn=%0d alu=%h qb=%h",
                             n, a.wreg, a.m2reg, a.wmem, a.wn, a.alu, a.qb,
                             e.wreg, e.m2reg, e.wmem, e.wn, e.alu, e.qb);
                end
            end
        end
    end

    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [3:0] aluc, input logic [1:0] sela,
                         input logic [1:0] selb, input logic [4:0] wn,
                         input logic [31:0] qa, input logic [31:0] qb,
                         input logic [31:0] imm);
        IDwreg       = wreg;
        IDm2reg      = m2reg;
        IDwmem       = wmem;
        IDaluc       = aluc;
        IDselectAlua = sela;
        IDselectAlub = selb;
        IDwn         = wn;
        IDqa         = qa;
        IDqb         = qb;
        IDsaOrImme   = imm;
    endtask

    task automatic expect_out(input string nm, input logic wreg, input logic m2reg,
                              input logic wmem, input logic [4:0] wn,
                              input logic [31:0] alu, input logic [31:0] qb);
        exp_t e;
        e = '{wreg, m2reg, wmem, wn, alu, qb};
        sb_q.push_back(e);
        name_q.push_back(nm);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard not drained, got pending=%0d want 0", nm, sb_q.size());
            sb_q.delete();
            name_q.delete();
        end
    endtask

    // Drive after a falling edge, then check once the next rising edge has loaded
    task automatic step(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [3:0] aluc, input logic [1:0] sela,
                        input logic [1:0] selb, input logic [4:0] wn,
                        input logic [31:0] qa, input logic [31:0] qb,
                        input logic [31:0] imm);
        @(negedge clk);
        drive(wreg, m2reg, wmem, aluc, sela, selb, wn, qa, qb, imm);
        @(posedge clk);
        #2;
    endtask

    initial begin
        clrn         = 1'b0;
        MEMaluResult = 32'h1111_1111;
        WBdata       = 32'h2222_2222;
        drive(1'b1, 1'b1, 1'b1, 4'b0101, 2'b11, 2'b11, 5'd31,
              32'hFFFF_FFFF, 32'h1234_5678, 32'hAAAA_5555);
        #1 clrn = 1'b1;
        #1;
        expect_out("reset_async", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        expect_out("reset_held", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        clrn = 1'b0;

        step(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 5'd3, 32'd5, 32'd7, 32'd0);
        expect_out("add", 1'b1, 1'b0, 1'b0, 5'd3, 32'd12, 32'd7);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 5'd9, 32'd100, 32'd7, 32'd0);
        #1;
        expect_out("latency_hold", 1'b1, 1'b0, 1'b0, 5'd3, 32'd12, 32'd7);
        @(posedge clk);
        #2;
        expect_out("latency_load", 1'b0, 1'b0, 1'b0, 5'd9, 32'd107, 32'd7);

        @(negedge clk);
        MEMaluResult = 32'h10;
        WBdata       = 32'h3;
        step(1'b1, 1'b0, 1'b0, 4'b0100, 2'b01, 2'b10, 5'd4, 32'h0000_AAAA, 32'h0000_5555, 32'd0);
        expect_out("fwd_sub", 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_000D, 32'h0000_5555);
        @(negedge clk);
        MEMaluResult = 32'h20;
        #1;
        expect_out("fwd_live", 1'b1, 1'b0, 1'b0, 5'd4, 32'h0000_001D, 32'h0000_5555);

        step(1'b1, 1'b0, 1'b0, 4'b0011, 2'b11, 2'b00, 5'd5, 32'd0, 32'h8000_0000, 32'd4);
        expect_out("sll", 1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h8000_0000);
        step(1'b1, 1'b0, 1'b0, 4'b0111, 2'b11, 2'b00, 5'd6, 32'd0, 32'h8000_0000, 32'd4);
        expect_out("srl", 1'b1, 1'b0, 1'b0, 5'd6, 32'h0800_0000, 32'h8000_0000);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 2'b11, 2'b00, 5'd7, 32'd0, 32'h8000_0000, 32'd4);
        expect_out("sra", 1'b1, 1'b0, 1'b0, 5'd7, 32'hF800_0000, 32'h8000_0000);

        step(1'b1, 1'b0, 1'b0, 4'b0110, 2'b00, 2'b11, 5'd8, 32'h5A5A_5A5A, 32'd0, 32'h0000_1234);
        expect_out("lui", 1'b1, 1'b0, 1'b0, 5'd8, 32'h1234_0000, 32'h0);

        step(1'b0, 1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'd8);
        expect_out("sw", 1'b0, 1'b0, 1'b1, 5'd0, 32'h108, 32'hDEAD_BEEF);

        step(1'b1, 1'b0, 1'b0, 4'b0001, 2'b00, 2'b00, 5'd10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        expect_out("and", 1'b1, 1'b0, 1'b0, 5'd10, 32'hF000_F000, 32'hFF00_FF00);
        step(1'b1, 1'b0, 1'b0, 4'b0101, 2'b00, 2'b00, 5'd11, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        expect_out("or", 1'b1, 1'b0, 1'b0, 5'd11, 32'hFFF0_FFF0, 32'hFF00_FF00);
        step(1'b1, 1'b0, 1'b0, 4'b0010, 2'b00, 2'b00, 5'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        expect_out("xor", 1'b1, 1'b0, 1'b0, 5'd12, 32'h0FF0_0FF0, 32'hFF00_FF00);

        step(1'b1, 1'b0, 1'b0, 4'b0100, 2'b00, 2'b00, 5'd13, 32'd0, 32'd1, 32'd0);
        expect_out("sub_wrap", 1'b1, 1'b0, 1'b0, 5'd13, 32'hFFFF_FFFF, 32'd1);

        step(1'b1, 1'b1, 1'b0, 4'b1000, 2'b10, 2'b11, 5'd14, 32'd0, 32'h77, 32'hFFFF_FFFF);
        expect_out("lw_add_wrap", 1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_0002, 32'h77);

        @(negedge clk);
        clrn = 1'b1;
        #1;
        expect_out("reset_mid", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        clrn = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b01, 5'd21, 32'd9, 32'h55, 32'd0);
        @(posedge clk);
        #2;
        expect_out("reset_release", 1'b1, 1'b0, 1'b0, 5'd21, 32'h29, 32'h55);

        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
